// File: rtl/param_fifo.sv
// Synchronous FIFO with almost-full/almost-empty thresholds and sticky error flags.
// The read path is either a registered output or first-word-fall-through.
module param_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  input  logic                     write,
  input  logic                     read,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic              rd_ok, wr_ok;

  // Flags come straight off the registered count.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A full FIFO can still take a write if a read frees a slot in the same cycle.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  // Storage is never reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[head] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) head <= head + AW'(1);
      if (rd_ok) tail <= tail + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write && !wr_ok) overflow  <= 1'b1;
      if (read  && !rd_ok) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout       = mem[tail];
      assign dout_valid = ~empty;
    end else begin : g_reg
      logic [DATA_W-1:0] dq;
      logic              dv;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dq <= '0;
          dv <= 1'b0;
        end else if (clear) begin
          dq <= '0;
          dv <= 1'b0;
        end else begin
          dv <= rd_ok;
          if (rd_ok) dq <= mem[tail];
        end
      end
      assign dout       = dq;
      assign dout_valid = dv;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Three FIFO configurations driven by one directed stream; a queue model is
// checked every cycle, and literal expectations pin the key scenarios.
module tb_param_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  logic [7:0] dout_w [3];
  logic       dv_w [3], fl_w [3], em_w [3], af_w [3], ae_w [3], ov_w [3], un_w [3];
  logic [2:0] c0, c1;
  logic [4:0] c2;
  int         cnt_w [3];
  assign cnt_w[0] = int'(c0);
  assign cnt_w[1] = int'(c1);
  assign cnt_w[2] = int'(c2);

  // 0: DEPTH 4 registered, 1: DEPTH 4 FWFT, 2: DEPTH 16 registered
  param_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .clear(clr), .din(din), .write(wr), .read(rd),
    .dout(dout_w[0]), .dout_valid(dv_w[0]), .count(c0), .full(fl_w[0]), .empty(em_w[0]),
    .almost_full(af_w[0]), .almost_empty(ae_w[0]), .overflow(ov_w[0]), .underflow(un_w[0]));
  param_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .clear(clr), .din(din), .write(wr), .read(rd),
    .dout(dout_w[1]), .dout_valid(dv_w[1]), .count(c1), .full(fl_w[1]), .empty(em_w[1]),
    .almost_full(af_w[1]), .almost_empty(ae_w[1]), .overflow(ov_w[1]), .underflow(un_w[1]));
  param_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u2 (
    .clk(clk), .rst(rst), .clear(clr), .din(din), .write(wr), .read(rd),
    .dout(dout_w[2]), .dout_valid(dv_w[2]), .count(c2), .full(fl_w[2]), .empty(em_w[2]),
    .almost_full(af_w[2]), .almost_empty(ae_w[2]), .overflow(ov_w[2]), .underflow(un_w[2]));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Behavioural model: a queue per configuration.
  int         DEP [3] = '{4, 4, 16};
  int         AFL [3] = '{2, 2, 14};
  int         AEL [3] = '{2, 2, 2};
  int         FW  [3] = '{0, 1, 0};
  logic [7:0] mq [3][$];
  logic [7:0] mdout [3] = '{8'h00, 8'h00, 8'h00};
  bit         mdv [3]   = '{0, 0, 0};
  bit         mov [3]   = '{0, 0, 0};
  bit         mun [3]   = '{0, 0, 0};
  bit         rok, wok;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        mq[i].delete();
        mov[i] = 0; mun[i] = 0; mdv[i] = 0; mdout[i] = 8'h00;
      end else begin
        rok = rd && (mq[i].size() != 0);
        wok = wr && ((mq[i].size() < DEP[i]) || rok);
        if (wr && !wok) mov[i] = 1;
        if (rd && !rok) mun[i] = 1;
        mdv[i] = 0;
        if (rok) begin
          mdout[i] = mq[i].pop_front();
          mdv[i]   = 1;
        end
        if (wok) mq[i].push_back(din);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m%0d.count", i), cnt_w[i], mq[i].size());
      chk($sformatf("m%0d.full", i), fl_w[i], int'(mq[i].size() == DEP[i]));
      chk($sformatf("m%0d.empty", i), em_w[i], int'(mq[i].size() == 0));
      chk($sformatf("m%0d.afull", i), af_w[i], int'(mq[i].size() >= AFL[i]));
      chk($sformatf("m%0d.aempty", i), ae_w[i], int'(mq[i].size() <= AEL[i]));
      chk($sformatf("m%0d.overflow", i), ov_w[i], int'(mov[i]));
      chk($sformatf("m%0d.underflow", i), un_w[i], int'(mun[i]));
      if (FW[i] != 0) begin
        chk($sformatf("m%0d.dout_valid", i), dv_w[i], int'(mq[i].size() != 0));
        if (mq[i].size() != 0) chk($sformatf("m%0d.dout", i), dout_w[i], mq[i][0]);
      end else begin
        chk($sformatf("m%0d.dout_valid", i), dv_w[i], int'(mdv[i]));
        chk($sformatf("m%0d.dout", i), dout_w[i], mdout[i]);
      end
    end
  end

  task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
    wr = w; rd = r; clr = c; din = d;
    @(posedge clk);
    #1;
    wr = 0; rd = 0; clr = 0;
  endtask

  logic [7:0] drain [4] = '{8'hB2, 8'hC3, 8'hD4, 8'hE5};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", cnt_w[0], 0);
    chk("rst.empty", em_w[0], 1);
    chk("rst.aempty", ae_w[0], 1);
    chk("rst.full", fl_w[0], 0);
    chk("rst.afull", af_w[0], 0);
    chk("rst.dout_valid", dv_w[0], 0);
    rst = 0;

    cyc(1, 0, 0, 8'hA1); cyc(1, 0, 0, 8'hB2); cyc(1, 0, 0, 8'hC3); cyc(1, 0, 0, 8'hD4);
    chk("fill4.full", fl_w[0], 1);
    chk("fill4.count", cnt_w[0], 4);
    cyc(1, 0, 0, 8'h55);
    chk("ovf.flag", ov_w[0], 1);
    chk("ovf.count", cnt_w[0], 4);
    cyc(1, 1, 0, 8'hE5);
    chk("fullrw.count", cnt_w[0], 4);
    chk("fullrw.dout", dout_w[0], 8'hA1);
    chk("fullrw.valid", dv_w[0], 1);
    chk("fullrw.ovf_kept", ov_w[0], 1);
    chk("fwft.head", dout_w[1], 8'hB2);
    cyc(0, 0, 0, 8'h00);
    chk("idle.valid", dv_w[0], 0);
    chk("idle.hold", dout_w[0], 8'hA1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 8'h00);
      chk($sformatf("drain%0d.dout", k), dout_w[0], drain[k]);
      chk($sformatf("drain%0d.valid", k), dv_w[0], 1);
    end
    chk("drained.empty", em_w[0], 1);
    cyc(0, 1, 0, 8'h00);
    chk("udf.flag", un_w[0], 1);
    chk("udf.count", cnt_w[0], 0);
    chk("udf.dout", dout_w[0], 8'hE5);
    cyc(0, 0, 1, 8'h00);
    chk("clr.udf", un_w[0], 0);
    chk("clr.ovf", ov_w[0], 0);

    cyc(1, 0, 0, 8'h58);
    chk("fwft.x", dout_w[1], 8'h58);
    chk("fwft.valid", dv_w[1], 1);
    cyc(0, 1, 0, 8'h00);
    chk("fwft.empty", em_w[1], 1);
    chk("fwft.novalid", dv_w[1], 0);
    chk("reg.x", dout_w[0], 8'h58);

    cyc(1, 1, 1, 8'h77);
    chk("clrreq.count", cnt_w[2], 0);
    chk("clrreq.udf", un_w[2], 0);
    chk("clrreq.dout", dout_w[0], 8'h00);
    chk("lvl0.aempty", ae_w[2], 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0, 8'(k));
      chk($sformatf("lvl%0d.count", k), cnt_w[2], k);
      chk($sformatf("lvl%0d.aempty", k), ae_w[2], int'(k <= 2));
      chk($sformatf("lvl%0d.afull", k), af_w[2], int'(k >= 14));
      chk($sformatf("lvl%0d.full", k), fl_w[2], int'(k == 16));
    end
    cyc(1, 0, 0, 8'hFF);
    chk("lvl17.ovf", ov_w[2], 1);
    chk("lvl17.count", cnt_w[2], 16);
    cyc(0, 0, 1, 8'h00);

    cyc(1, 0, 0, 8'h31); cyc(1, 0, 0, 8'h32); cyc(1, 0, 0, 8'h33); cyc(1, 0, 0, 8'h34);
    cyc(0, 1, 0, 8'h00);
    chk("pre_rst.count", cnt_w[0], 3);
    chk("pre_rst.dout", dout_w[0], 8'h31);
    #2 rst = 1;
    #1;
    chk("arst.count", cnt_w[0], 0);
    chk("arst.empty", em_w[0], 1);
    chk("arst.aempty", ae_w[0], 1);
    chk("arst.afull", af_w[0], 0);
    chk("arst.full", fl_w[0], 0);
    chk("arst.dout", dout_w[0], 0);
    chk("arst.valid", dv_w[0], 0);
    chk("arst.fwft_empty", em_w[1], 1);
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 0, 0, 8'h79);
    cyc(0, 1, 0, 8'h00);
    chk("post_rst.dout", dout_w[0], 8'h79);
    chk("post_rst.valid", dv_w[0], 1);
    repeat (3) cyc(0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
